fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001: Parameter START_PC, 32'h80020000, word address of the first instruction fetched after reset.
REQ-002: clock  input  1  single clock; all state updates on rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: stall  input  1  decode cannot accept; holds the current instruction.
REQ-005: branch_taken  input  1  one-cycle redirect request.
REQ-006: branch_target  input  32  redirect byte address.
REQ-007: mem_ready  input  1  instruction memory response valid.
REQ-008: mem_rdata  input  32  instruction word, valid when mem_ready=1.
REQ-009: mem_req  output  1  read request, one cycle per fetch.
REQ-010: mem_addr  output  32  word-aligned fetch address, valid when mem_req=1.
REQ-011: insn  output  32  instruction word to decode.
REQ-012: pc  output  32  address of insn.
REQ-013: enable_decode  output  1  insn/pc valid for decode.
REQ-014: addr_error  output  1  one-cycle pulse: misaligned branch_target seen.
REQ-015: insn_count  output  32  count of instructions accepted by decode.

Function
REQ-016: States SHALL be IDLE, FETCH, WAIT, VALID, DRAIN; all outputs registered or Moore-decoded from state.
REQ-017: IDLE -> FETCH unconditionally on the first edge after reset deasserts.
REQ-018: In FETCH, mem_req=1 and mem_addr=fetch_addr for exactly one cycle, then -> WAIT.
REQ-019: In WAIT, on mem_ready=1: insn<=mem_rdata, pc<=fetch_addr, enable_decode<=1, -> VALID; else stay WAIT (no timeout).
REQ-020: In VALID, enable_decode=1 and insn/pc held stable while stall=1.
REQ-021: In VALID with stall=0 (transfer): insn_count+=1, enable_decode<=0, fetch_addr<=fetch_addr+4, -> FETCH.
REQ-022: Minimum throughput: one instruction per 3 cycles (FETCH, WAIT with mem_ready, VALID with stall=0).
REQ-023: branch_taken=1 in FETCH, VALID, or IDLE: fetch_addr<={branch_target[31:2],2'b00}, enable_decode<=0, -> FETCH; no transfer or insn_count increment that cycle, even when stall=0.
REQ-024: branch_taken=1 in WAIT with mem_ready=0: load fetch_addr as REQ-023, -> DRAIN.
REQ-025: branch_taken=1 in WAIT with mem_ready=1: discard mem_rdata, load fetch_addr, -> FETCH; enable_decode stays 0.
REQ-026: In DRAIN, mem_req=0; on mem_ready, discard data, -> FETCH; a further branch_taken in DRAIN only reloads fetch_addr.
REQ-027: addr_error=1 in the cycle after any accepted branch_taken with branch_target[1:0]!=0; otherwise 0.
REQ-028: fetch_addr+4 and insn_count SHALL wrap modulo 2^32 without flagging.
REQ-029: mem_ready outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-030: While reset=1: state=IDLE, fetch_addr=START_PC, insn=0, pc=0, enable_decode=0, mem_req=0, mem_addr=0, addr_error=0, insn_count=0.
REQ-031: Reset asserted mid-operation SHALL abandon any in-flight fetch immediately; no response is captured after reset.

Verification
REQ-032: Reset release, memory ready 1 cycle after req, stall=0 -> mem_addr 80020000, 80020004, 80020008 at 3-cycle spacing; pc matches; insn_count=3 after third transfer.
REQ-033: stall=1 for 5 cycles in VALID with insn=32'h00851020 -> insn/pc/enable_decode unchanged 5 cycles; insn_count unchanged; next mem_req only after stall drops.
REQ-034: branch_taken, target 32'h80020100, in WAIT, mem_ready 4 cycles later -> DRAIN, response discarded, enable_decode stays 0, next mem_addr=80020100.
REQ-035: branch_taken with mem_ready same cycle in WAIT -> data dropped, next mem_req addr=target, no enable_decode pulse.
REQ-036: branch_target=32'h80020102 -> addr_error one-cycle pulse, mem_addr=80020100.
REQ-037: fetch_addr=32'hFFFFFFFC transfer -> next mem_addr=0; reset asserted in WAIT then mem_ready -> outputs stay at reset values, restart from START_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word read per instruction, waits for the
// memory response, presents the word to decode and holds it under stall.
// Branch redirects reload the fetch address from any state. A redirect that
// arrives while a read is outstanding sends the FSM to DRAIN, so the stale
// response is consumed and dropped before the new fetch is issued.
//
// Ports:
//   clock, reset           clock and asynchronous active-high reset
//   stall                  decode cannot accept the presented instruction
//   branch_taken/_target   one-cycle redirect request and byte target
//   mem_ready, mem_rdata   instruction memory response
//   mem_req, mem_addr      one-cycle read request and word-aligned address
//   insn, pc               instruction word and its address for decode
//   enable_decode          insn/pc valid
//   addr_error             pulse after a redirect to a misaligned target
//   insn_count             instructions accepted by decode (wraps)
module fetch_unit #(
    parameter logic [31:0] START_PC = 32'h80020000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        enable_decode,
    output logic        addr_error,
    output logic [31:0] insn_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   fetch_addr_q, fetch_addr_d;
    logic [XLEN-1:0]   insn_d, pc_d, mem_addr_d, insn_count_d;
    logic              enable_decode_d, mem_req_d, addr_error_d;
    logic [XLEN-1:0]   branch_addr;

    // Redirect target forced onto a word boundary
    assign branch_addr = {branch_target[XLEN-1:2], 2'b00};

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fetch_addr_q  <= START_PC;
            insn          <= '0;
            pc            <= '0;
            enable_decode <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            addr_error    <= 1'b0;
            insn_count    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            insn          <= insn_d;
            pc            <= pc_d;
            enable_decode <= enable_decode_d;
            mem_req       <= mem_req_d;
            mem_addr      <= mem_addr_d;
            addr_error    <= addr_error_d;
            insn_count    <= insn_count_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d         = state_q;
        fetch_addr_d    = fetch_addr_q;
        insn_d          = insn;
        pc_d            = pc;
        enable_decode_d = enable_decode;
        insn_count_d    = insn_count;

        case (state_q)
            IDLE: begin
                if (branch_taken) fetch_addr_d = branch_addr;
                state_d = FETCH;
            end
            FETCH: begin
                if (branch_taken) begin
                    fetch_addr_d = branch_addr;
                    state_d      = FETCH;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (branch_taken) begin
                    // Same-cycle response is dropped; otherwise drain it later
                    fetch_addr_d = branch_addr;
                    state_d      = mem_ready ? FETCH : DRAIN;
                end else if (mem_ready) begin
                    insn_d          = mem_rdata;
                    pc_d            = fetch_addr_q;
                    enable_decode_d = 1'b1;
                    state_d         = VALID;
                end
            end
            VALID: begin
                if (branch_taken) begin
                    fetch_addr_d    = branch_addr;
                    enable_decode_d = 1'b0;
                    state_d         = FETCH;
                end else if (!stall) begin
                    insn_count_d    = insn_count + XLEN'(1);
                    enable_decode_d = 1'b0;
                    fetch_addr_d    = fetch_addr_q + XLEN'(4);
                    state_d         = FETCH;
                end
            end
            DRAIN: begin
                if (branch_taken) fetch_addr_d = branch_addr;
                if (mem_ready) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase

        // Request registered so it is high exactly while the FSM sits in FETCH
        mem_req_d    = (state_d == FETCH);
        mem_addr_d   = mem_req_d ? fetch_addr_d : mem_addr;
        addr_error_d = branch_taken && (branch_target[1:0] != 2'b00);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight-line steps with hand-computed
// expectations checked by immediate assertions.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        enable_decode;
    logic        addr_error;
    logic [31:0] insn_count;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.START_PC(32'h80020000)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .insn          (insn),
        .pc            (pc),
        .enable_decode (enable_decode),
        .addr_error    (addr_error),
        .insn_count    (insn_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_req"},  32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_insn"},     insn, 32'd0);
        check({tag, "_pc"},       pc, 32'd0);
        check({tag, "_en"},       32'(enable_decode), 32'd0);
        check({tag, "_aerr"},     32'(addr_error), 32'd0);
        check({tag, "_count"},    insn_count, 32'd0);
    endtask

    // Starting in FETCH: check the request, answer it one cycle later, and
    // end in VALID with the word presented to decode.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_req"},  32'(mem_req), 32'd1);
        check({tag, "_addr"}, mem_addr, addr);
        tick();
        check({tag, "_req_drop"}, 32'(mem_req), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = data;
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check({tag, "_en"},   32'(enable_decode), 32'd1);
        check({tag, "_insn"}, insn, data);
        check({tag, "_pc"},   pc, addr);
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        mem_ready     = 1'b0;
        mem_rdata     = 32'h0;
        tick();
        tick();
        check_reset_values("reset");

        // Sequential fetch at three-cycle spacing
        reset = 1'b0;
        tick();
        do_fetch("f0", 32'h80020000, 32'h11111111);
        tick();
        check("f0_count", insn_count, 32'd1);
        check("f0_en_clr", 32'(enable_decode), 32'd0);
        do_fetch("f1", 32'h80020004, 32'h22222222);
        tick();
        check("f1_count", insn_count, 32'd2);
        do_fetch("f2", 32'h80020008, 32'h00851020);

        // Stall holds the presented instruction
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_insn",  insn, 32'h00851020);
            check("stall_pc",    pc, 32'h80020008);
            check("stall_en",    32'(enable_decode), 32'd1);
            check("stall_count", insn_count, 32'd2);
            check("stall_req",   32'(mem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("f2_count", insn_count, 32'd3);
        check("f3_req",   32'(mem_req), 32'd1);
        check("f3_addr",  mem_addr, 32'h8002000C);

        // Branch in WAIT without response: drain, discard late data
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h80020100;
        tick();
        branch_taken = 1'b0;
        check("drain_req",  32'(mem_req), 32'd0);
        check("drain_aerr", 32'(addr_error), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_en",   32'(enable_decode), 32'd0);
            check("drain_req2", 32'(mem_req), 32'd0);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0;
        check("drain_out_req",  32'(mem_req), 32'd1);
        check("drain_out_addr", mem_addr, 32'h80020100);
        check("drain_out_en",   32'(enable_decode), 32'd0);
        check("drain_out_insn", insn, 32'h00851020);

        // Branch in WAIT with same-cycle response: data dropped
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h80020200;
        mem_ready     = 1'b1;
        mem_rdata     = 32'hBAD0BAD0;
        tick();
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        check("bw_req",  32'(mem_req), 32'd1);
        check("bw_addr", mem_addr, 32'h80020200);
        check("bw_en",   32'(enable_decode), 32'd0);
        check("bw_insn", insn, 32'h00851020);

        // Misaligned target from FETCH: aligned address, one-cycle error pulse
        branch_taken  = 1'b1;
        branch_target = 32'h80020102;
        tick();
        branch_taken = 1'b0;
        check("mis_aerr", 32'(addr_error), 32'd1);
        check("mis_req",  32'(mem_req), 32'd1);
        check("mis_addr", mem_addr, 32'h80020100);
        tick();
        check("mis_aerr_clr", 32'(addr_error), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h33333333;
        tick();
        mem_ready = 1'b0;
        check("mis_pc", pc, 32'h80020100);

        // Branch in VALID with stall=0: no transfer; then wrap of fetch address
        branch_taken  = 1'b1;
        branch_target = 32'hFFFFFFFC;
        tick();
        branch_taken = 1'b0;
        check("bv_count", insn_count, 32'd3);
        check("bv_en",    32'(enable_decode), 32'd0);
        do_fetch("wrap", 32'hFFFFFFFC, 32'h44444444);
        tick();
        check("wrap_count", insn_count, 32'd4);
        check("wrap_addr",  mem_addr, 32'h00000000);

        // Reset during WAIT abandons the fetch
        tick();
        reset = 1'b1;
        #1;
        check_reset_values("rst_wait");
        mem_ready = 1'b1;
        mem_rdata = 32'h55555555;
        tick();
        check_reset_values("rst_ready");
        reset = 1'b0;
        tick();
        mem_ready = 1'b0;
        check("restart_req",  32'(mem_req), 32'd1);
        check("restart_addr", mem_addr, 32'h80020000);
        check("restart_en",   32'(enable_decode), 32'd0);
        check("restart_insn", insn, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
